// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the barrel shifter: default geometry and the
// encoding of the shift-direction control.
package barrel_shifter_pkg;

  // Default data path width and the matching shift-amount width.
  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_SHIFT_W = 5;

  // Direction encoding seen on the dir input.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Distance moved by logarithmic stage k.
  function automatic int stage_dist(input int k);
    return 1 << k;
  endfunction

endpackage : barrel_shifter_pkg

// File: rtl/barrel_shift_stage.sv
// One stage of the logarithmic shifter: when enabled, moves the word by a
// fixed DIST bits in the requested direction, zero-filling vacated bits.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIST  = 1
) (
  input  logic             dir,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result
);

  // Pass the word through, or shift it by DIST when this stage is enabled.
  always_comb begin
    // NOTE: result gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    result = data;
    if (en) begin
      if (dir == DIR_RIGHT) begin
        result = data >> DIST;
      end else begin
        result = data << DIST;
      end
    end
  end

endmodule : barrel_shift_stage

// File: rtl/barrel_shifter.sv
// Logical left/right barrel shifter with a combinational result and a
// one-cycle registered copy qualified by out_valid.
module barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHIFT_W = DEFAULT_SHIFT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dir,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHIFT_W-1:0] shift_amt,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_q,
  output logic               out_valid
);

  // stage_data[k] is the word entering stage k; the last entry is the result.
  logic [WIDTH-1:0] stage_data [SHIFT_W+1];

  assign stage_data[0] = data;

  // Stage k shifts by 2^k under control of shift_amt[k]; direction is
  // applied at every stage so left and right share one chain.
  for (genvar k = 0; k < SHIFT_W; k++) begin : gen_stage
    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (stage_dist(k))
    ) u_stage (
      .dir    (dir),
      .en     (shift_amt[k]),
      .data   (stage_data[k]),
      .result (stage_data[k+1])
    );
  end

  // The combinational result never touches clk or rst.
  assign out = stage_data[SHIFT_W];

  // Output register: reset wins, a valid input loads, otherwise hold data
  // and drop the qualifier.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out_q     <= out;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule : barrel_shifter

// File: tb/tb_barrel_shifter.sv
// Directed and random checks of the barrel shifter's combinational and
// registered outputs against hand-computed values and an operator model.
module tb_barrel_shifter;

  logic        clk;
  logic        rst;
  logic        dir;
  logic [31:0] data;
  logic [4:0]  shift_amt;
  logic        in_valid;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  barrel_shifter #(
    .WIDTH   (32),
    .SHIFT_W (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dir       (dir),
    .data      (data),
    .shift_amt (shift_amt),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one vector on the combinational path and compare out.
  task automatic comb_vec(input string tag, input logic d,
                          input logic [31:0] v, input logic [4:0] amt,
                          input logic [31:0] exp);
    dir       = d;
    data      = v;
    shift_amt = amt;
    #1;
    check(tag, out, exp);
  endtask

  function automatic logic [31:0] model(input logic d, input logic [31:0] v,
                                        input logic [4:0] amt);
    return d ? (v >> amt) : (v << amt);
  endfunction

  logic        r_dir;
  logic [31:0] r_data;
  logic [4:0]  r_amt;
  logic        r_valid;
  logic [31:0] r_exp;
  logic [31:0] model_q;
  logic        model_v;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    dir       = 1'b0;
    data      = 32'hDEAD_BEEF;
    shift_amt = 5'd3;

    // Reset with in_valid also asserted: reset must win.
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_q", out_q, 32'h0);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);

    // Combinational path is unaffected while reset is held.
    comb_vec("comb_during_rst", 1'b0, 32'd30000, 5'd1, 32'd60000);
    @(posedge clk);
    #1;
    check("rst_priority_q", out_q, 32'h0);
    check("rst_priority_valid", {31'b0, out_valid}, 32'h0);

    rst      = 1'b0;
    in_valid = 1'b0;

    // Directed combinational vectors.
    comb_vec("left_30000_1",  1'b0, 32'd30000,     5'd1,  32'd60000);
    comb_vec("right_30000_1", 1'b1, 32'd30000,     5'd1,  32'd15000);
    comb_vec("left_ones_1",   1'b0, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE);
    comb_vec("right_one_1",   1'b1, 32'h0000_0001, 5'd1,  32'h0000_0000);
    comb_vec("right_msb_31",  1'b1, 32'h8000_0000, 5'd31, 32'h0000_0001);
    comb_vec("left_amt0",     1'b0, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5);
    comb_vec("right_amt0",    1'b1, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5);
    comb_vec("left_a5_4",     1'b0, 32'hA5A5_A5A5, 5'd4,  32'h5A5A_5A50);
    comb_vec("right_a5_4",    1'b1, 32'hA5A5_A5A5, 5'd4,  32'h0A5A_5A5A);
    comb_vec("left_1234_8",   1'b0, 32'h1234_5678, 5'd8,  32'h3456_7800);
    comb_vec("right_1234_16", 1'b1, 32'h1234_5678, 5'd16, 32'h0000_1234);
    comb_vec("right_ones_31", 1'b1, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001);
    comb_vec("left_ones_31",  1'b0, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000);
    comb_vec("left_msb_1",    1'b0, 32'h8000_0000, 5'd1,  32'h0000_0000);
    comb_vec("right_nosign",  1'b1, 32'hF000_0000, 5'd2,  32'h3C00_0000);
    comb_vec("left_mixed_21", 1'b0, 32'h0000_0C35, 5'd21, 32'h86A0_0000);

    // Registered path: load, hold, reset.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    comb_vec("reg_load_comb", 1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000);
    @(posedge clk);
    #1;
    check("reg_load_q", out_q, 32'h8000_0000);
    check("reg_load_valid", {31'b0, out_valid}, 32'h1);
    in_valid = 1'b0;
    data     = 32'h0000_00FF;
    @(posedge clk);
    #1;
    check("reg_hold_q", out_q, 32'h8000_0000);
    check("reg_hold_valid", {31'b0, out_valid}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reg_rst_q", out_q, 32'h0);
    check("reg_rst_valid", {31'b0, out_valid}, 32'h0);
    rst = 1'b0;

    // Random vectors, with in_valid mostly high so both load and hold occur.
    model_q = 32'h0;
    model_v = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      r_dir   = 1'($urandom_range(0, 1));
      r_data  = $urandom;
      r_amt   = 5'($urandom_range(0, 31));
      r_valid = ($urandom_range(0, 3) != 0);
      r_exp   = model(r_dir, r_data, r_amt);
      in_valid = r_valid;
      comb_vec("rand_comb", r_dir, r_data, r_amt, r_exp);
      @(posedge clk);
      #1;
      if (r_valid) model_q = r_exp;
      model_v = r_valid;
      check("rand_q", out_q, model_q);
      check("rand_valid", {31'b0, out_valid}, {31'b0, model_v});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_barrel_shifter
